ppu_reg_port: RTL and testbench

//  Parametrised CPU-side register port for the PPU: decodes RS/RnW accesses, holds CTRL0/CTRL1,

---
 rtl/ppu_reg_port_if.sv | 34 +++
 rtl/ppu_reg_port.sv | 187 ++++++++++++++++++
 tb/tb_ppu_reg_port.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/ppu_reg_port_if.sv
// CPU-side bus bundle for the PPU register port.
// Groups the CPU access request fields with the registered read data, the
// read/write strobes and the second-write qualifier handed to the PPU core.
interface ppu_reg_port_if #(
    parameter int RS_W = 3,
    parameter int DW   = 8
);
    localparam int NREG = 1 << RS_W;

    // Access request from the CPU bus side
    logic            CPU_SEL;
    logic            RnW;
    logic [RS_W-1:0] RS;
    logic [DW-1:0]   DB_IN;
    // Read data from the PPU core for registers not held in the port
    logic [DW-1:0]   EXT_RD;

    // Port responses
    logic [DW-1:0]   DB_OUT;
    logic            DB_RDY;
    logic [NREG-1:0] WR_STB;
    logic [NREG-1:0] RD_STB;
    logic            SCND;

    modport master (
        output CPU_SEL, RnW, RS, DB_IN, EXT_RD,
        input  DB_OUT, DB_RDY, WR_STB, RD_STB, SCND
    );

    modport slave (
        input  CPU_SEL, RnW, RS, DB_IN, EXT_RD,
        output DB_OUT, DB_RDY, WR_STB, RD_STB, SCND
    );
endinterface

// File: rtl/ppu_reg_port.sv
// CPU-side register port of the PPU.
// Decodes register accesses, holds CTRL0/CTRL1, runs the shared first/second
// write toggle for double-write registers, owns the vblank flag and keeps a
// decaying open-bus latch that answers reads of write-only registers.
// Every accepted access produces its strobes and read data one cycle later.
module ppu_reg_port #(
    parameter int                     RS_W      = 3,
    parameter int                     DW        = 8,
    parameter int                     CTRL0_IDX = 0,
    parameter int                     CTRL1_IDX = 1,
    parameter int                     STAT_IDX  = 2,
    parameter logic [(1<<RS_W)-1:0]   DBLW_MASK = 'b0110_0000,
    parameter logic [(1<<RS_W)-1:0]   WO_MASK   = 'b0110_1011,
    parameter int                     DECAY     = 4096
) (
    input  logic                PCLK,
    input  logic                n_RES,
    ppu_reg_port_if.slave       bus,
    input  logic                VBL_SET,
    input  logic                S0_HIT,
    input  logic                OVF,
    output logic [DW-1:0]       CTRL0,
    output logic [DW-1:0]       CTRL1,
    output logic                VBL,
    output logic                NMI_N
);

    localparam int NREG  = 1 << RS_W;
    // A zero DECAY still needs a one-bit counter so the declarations stay legal
    localparam int CNT_W = (DECAY == 0) ? 1 : $clog2(DECAY + 1);

    localparam logic [RS_W-1:0]  CTRL0_RS = RS_W'(CTRL0_IDX);
    localparam logic [RS_W-1:0]  CTRL1_RS = RS_W'(CTRL1_IDX);
    localparam logic [RS_W-1:0]  STAT_RS  = RS_W'(STAT_IDX);
    localparam logic [CNT_W-1:0] DECAY_C  = CNT_W'(DECAY);
    localparam logic [NREG-1:0]  ONE_HOT0 = NREG'(1);

    // Status word: live flags in the top three bits, open-bus bits below
    function automatic logic [DW-1:0] stat_word(
        input logic          vbl_bit,
        input logic          s0_bit,
        input logic          ovf_bit,
        input logic [DW-1:0] lat
    );
        return {vbl_bit, s0_bit, ovf_bit, lat[DW-4:0]};
    endfunction

    // Internal state
    logic             toggle;
    logic [DW-1:0]    latch;
    logic [CNT_W-1:0] cnt;

    // ---- p0: access decode (combinational, before the accepting edge) ----
    logic             acc_p0;
    logic             wr_p0;
    logic             rd_p0;
    logic             is_stat_p0;
    logic             is_wo_p0;
    logic             is_dblw_p0;
    logic             stat_rd_p0;
    logic             ext_rd_p0;
    logic [NREG-1:0]  sel_oh_p0;
    logic [DW-1:0]    rd_data_p0;
    logic             vbl_ret_p0;

    logic [DW-1:0]    latch_nxt;
    logic [CNT_W-1:0] cnt_nxt;

    // Classify the presented access; nothing is accepted while reset is held
    always_comb begin
        acc_p0     = bus.CPU_SEL & n_RES;
        wr_p0      = acc_p0 & ~bus.RnW;
        rd_p0      = acc_p0 &  bus.RnW;
        is_stat_p0 = (bus.RS == STAT_RS);
        is_wo_p0   = WO_MASK[bus.RS];
        is_dblw_p0 = DBLW_MASK[bus.RS];
        stat_rd_p0 = rd_p0 & is_stat_p0;
        ext_rd_p0  = rd_p0 & ~is_stat_p0 & ~is_wo_p0;
        sel_oh_p0  = ONE_HOT0 << bus.RS;
    end

    // Select read data; a coinciding VBL_SET masks the returned vblank bit
    always_comb begin
        vbl_ret_p0 = VBL & ~VBL_SET;
        rd_data_p0 = bus.EXT_RD;
        if (is_stat_p0) begin
            rd_data_p0 = stat_word(vbl_ret_p0, S0_HIT, OVF, latch);
        end else if (is_wo_p0) begin
            rd_data_p0 = latch;
        end
    end

    // Open-bus next state: decay first, then status refresh, full refresh wins
    always_comb begin
        cnt_nxt   = cnt;
        latch_nxt = latch;
        if (DECAY != 0 && cnt != DECAY_C) begin
            cnt_nxt = cnt + CNT_W'(1);
            if (cnt_nxt == DECAY_C) begin
                latch_nxt = '0;
            end
        end
        if (stat_rd_p0) begin
            latch_nxt[DW-1:DW-3] = rd_data_p0[DW-1:DW-3];
        end
        if (wr_p0) begin
            latch_nxt = bus.DB_IN;
            cnt_nxt   = '0;
        end else if (ext_rd_p0) begin
            latch_nxt = bus.EXT_RD;
            cnt_nxt   = '0;
        end
    end

    // ---- p1: registered results of the accepted access ----

    // One-cycle strobes, read-ready pulse and second-write qualifier
    always_ff @(posedge PCLK) begin
        if (!n_RES) begin
            bus.WR_STB <= '0;
            bus.RD_STB <= '0;
            bus.DB_RDY <= 1'b0;
            bus.SCND   <= 1'b0;
        end else begin
            bus.WR_STB <= wr_p0 ? sel_oh_p0 : '0;
            bus.RD_STB <= rd_p0 ? sel_oh_p0 : '0;
            bus.DB_RDY <= rd_p0;
            bus.SCND   <= wr_p0 ? toggle : 1'b0;
        end
    end

    // Shared first/second toggle: flipped by double-write registers, cleared by status reads
    always_ff @(posedge PCLK) begin
        if (!n_RES) begin
            toggle <= 1'b0;
        end else if (stat_rd_p0) begin
            toggle <= 1'b0;
        end else if (wr_p0 && is_dblw_p0) begin
            toggle <= ~toggle;
        end
    end

    // Control registers load on writes to their own index
    always_ff @(posedge PCLK) begin
        if (!n_RES) begin
            CTRL0 <= '0;
            CTRL1 <= '0;
        end else if (wr_p0) begin
            if (bus.RS == CTRL0_RS) CTRL0 <= bus.DB_IN;
            if (bus.RS == CTRL1_RS) CTRL1 <= bus.DB_IN;
        end
    end

    // Read data register holds its value between reads
    always_ff @(posedge PCLK) begin
        if (!n_RES) begin
            bus.DB_OUT <= '0;
        end else if (rd_p0) begin
            bus.DB_OUT <= rd_data_p0;
        end
    end

    // Vblank flag: a status read always wins over a coinciding set pulse
    always_ff @(posedge PCLK) begin
        if (!n_RES) begin
            VBL <= 1'b0;
        end else if (stat_rd_p0) begin
            VBL <= 1'b0;
        end else if (VBL_SET) begin
            VBL <= 1'b1;
        end
    end

    // Open-bus latch and its decay counter
    always_ff @(posedge PCLK) begin
        if (!n_RES) begin
            latch <= '0;
            cnt   <= '0;
        end else begin
            latch <= latch_nxt;
            cnt   <= cnt_nxt;
        end
    end

    assign NMI_N = ~(VBL & CTRL0[DW-1]);

endmodule

// File: tb/tb_ppu_reg_port.sv
// Directed bench for ppu_reg_port: reset, control writes, double-write
// toggle, status reads and vblank, open-bus latch and decay, reset discard.
module tb_ppu_reg_port;

    localparam int RS_W  = 3;
    localparam int DW    = 8;
    localparam int DECAY = 4096;

    logic PCLK;
    logic n_RES;
    logic VBL_SET;
    logic S0_HIT;
    logic OVF;
    logic [DW-1:0] CTRL0;
    logic [DW-1:0] CTRL1;
    logic VBL;
    logic NMI_N;

    int n_chk;
    int n_fail;

    ppu_reg_port_if #(.RS_W(RS_W), .DW(DW)) bus ();

    ppu_reg_port #(
        .RS_W  (RS_W),
        .DW    (DW),
        .DECAY (DECAY)
    ) dut (
        .PCLK    (PCLK),
        .n_RES   (n_RES),
        .bus     (bus),
        .VBL_SET (VBL_SET),
        .S0_HIT  (S0_HIT),
        .OVF     (OVF),
        .CTRL0   (CTRL0),
        .CTRL1   (CTRL1),
        .VBL     (VBL),
        .NMI_N   (NMI_N)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one edge and settle just after it
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic wr(input logic [RS_W-1:0] rs, input logic [DW-1:0] d);
        bus.CPU_SEL = 1'b1;
        bus.RnW     = 1'b0;
        bus.RS      = rs;
        bus.DB_IN   = d;
        tick();
        bus.CPU_SEL = 1'b0;
    endtask

    task automatic rd(input logic [RS_W-1:0] rs);
        bus.CPU_SEL = 1'b1;
        bus.RnW     = 1'b1;
        bus.RS      = rs;
        tick();
        bus.CPU_SEL = 1'b0;
    endtask

    initial begin
        n_chk       = 0;
        n_fail      = 0;
        n_RES       = 1'b0;
        VBL_SET     = 1'b0;
        S0_HIT      = 1'b0;
        OVF         = 1'b0;
        bus.CPU_SEL = 1'b0;
        bus.RnW     = 1'b1;
        bus.RS      = '0;
        bus.DB_IN   = '0;
        bus.EXT_RD  = '0;
        tick();
        tick();

        // Reset state
        check("rst_ctrl0",  CTRL0,      8'h00);
        check("rst_ctrl1",  CTRL1,      8'h00);
        check("rst_dbout",  bus.DB_OUT, 8'h00);
        check("rst_wrstb",  bus.WR_STB, 8'h00);
        check("rst_rdstb",  bus.RD_STB, 8'h00);
        check("rst_dbrdy",  bus.DB_RDY, 1'b0);
        check("rst_scnd",   bus.SCND,   1'b0);
        check("rst_vbl",    VBL,        1'b0);
        check("rst_nmi",    NMI_N,      1'b1);

        // 1: CTRL0 write, vblank pulse drives NMI
        n_RES = 1'b1;
        tick();
        wr(3'd0, 8'h80);
        check("t1_ctrl0",   CTRL0,      8'h80);
        check("t1_wrstb",   bus.WR_STB, 8'h01);
        check("t1_scnd",    bus.SCND,   1'b0);
        check("t1_nmi_pre", NMI_N,      1'b1);
        VBL_SET = 1'b1;
        tick();
        VBL_SET = 1'b0;
        check("t1_wrstb_idle", bus.WR_STB, 8'h00);
        check("t1_vbl",     VBL,        1'b1);
        check("t1_nmi",     NMI_N,      1'b0);

        // 2: double-write toggle, status read clears it
        wr(3'd5, 8'h11);
        check("t2_wrstb5",  bus.WR_STB, 8'h20);
        check("t2_scnd_a",  bus.SCND,   1'b0);
        wr(3'd5, 8'h22);
        check("t2_scnd_b",  bus.SCND,   1'b1);
        rd(3'd2);
        check("t2_rdstb",   bus.RD_STB, 8'h04);
        check("t2_dbrdy",   bus.DB_RDY, 1'b1);
        check("t2_stat",    bus.DB_OUT, 8'h82);
        check("t2_vbl_clr", VBL,        1'b0);
        check("t2_nmi_clr", NMI_N,      1'b1);
        wr(3'd6, 8'h33);
        check("t2_wrstb6",  bus.WR_STB, 8'h40);
        check("t2_scnd_c",  bus.SCND,   1'b0);
        check("t2_dbrdy_w", bus.DB_RDY, 1'b0);

        // 3: first write pending, status read with VBL=1 resets toggle
        rd(3'd2);
        VBL_SET = 1'b1;
        tick();
        VBL_SET = 1'b0;
        check("t3_vbl_set", VBL,        1'b1);
        wr(3'd5, 8'h44);
        check("t3_scnd_a",  bus.SCND,   1'b0);
        S0_HIT = 1'b1;
        rd(3'd2);
        S0_HIT = 1'b0;
        check("t3_stat",    bus.DB_OUT, 8'hC4);
        check("t3_vbl_clr", VBL,        1'b0);
        wr(3'd5, 8'h55);
        check("t3_scnd_b",  bus.SCND,   1'b0);
        rd(3'd3);
        check("t3_ob_wo",   bus.DB_OUT, 8'h55);

        // 4: VBL_SET coincident with status read
        OVF     = 1'b1;
        VBL_SET = 1'b1;
        rd(3'd2);
        VBL_SET = 1'b0;
        OVF     = 1'b0;
        check("t4_stat",    bus.DB_OUT, 8'h35);
        check("t4_vbl",     VBL,        1'b0);
        check("t4_nmi",     NMI_N,      1'b1);
        tick();
        check("t4_dbrdy_idle", bus.DB_RDY, 1'b0);
        check("t4_dbout_hold", bus.DB_OUT, 8'h35);

        // Readable external register refreshes the latch
        bus.EXT_RD = 8'h5A;
        rd(3'd7);
        bus.EXT_RD = 8'h00;
        check("ext_rd",     bus.DB_OUT, 8'h5A);
        check("ext_rdstb",  bus.RD_STB, 8'h80);
        rd(3'd3);
        check("ext_latch",  bus.DB_OUT, 8'h5A);

        // 5: open-bus latch and decay
        wr(3'd3, 8'hA5);
        rd(3'd3);
        check("t5_ob",      bus.DB_OUT, 8'hA5);
        repeat (100) tick();
        rd(3'd3);
        check("t5_ob_live", bus.DB_OUT, 8'hA5);
        repeat (DECAY + 2) tick();
        rd(3'd3);
        check("t5_ob_decay", bus.DB_OUT, 8'h00);

        // 6: write presented under reset is discarded
        wr(3'd1, 8'h3C);
        check("t6_ctrl1",   CTRL1,      8'h3C);
        wr(3'd5, 8'h01);
        check("t6_scnd_pre", bus.SCND,  1'b0);
        n_RES       = 1'b0;
        bus.CPU_SEL = 1'b1;
        bus.RnW     = 1'b0;
        bus.RS      = 3'd1;
        bus.DB_IN   = 8'h77;
        tick();
        bus.CPU_SEL = 1'b0;
        n_RES       = 1'b1;
        check("t6_ctrl1_rst", CTRL1,      8'h00);
        check("t6_ctrl0_rst", CTRL0,      8'h00);
        check("t6_wrstb",     bus.WR_STB, 8'h00);
        wr(3'd5, 8'h02);
        check("t6_toggle",    bus.SCND,   1'b0);
        check("t6_ctrl1_keep", CTRL1,     8'h00);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
